jtag_dtm: RTL and testbench

JTAG Debug Transport Module sitting directly upstream of the debug module. It drives the debug module's DMI request port (dmi_valid/dmi_wr/dmi_addr/dmi_wdata) and consumes its registered dmi_rdata. The TAP pins are asynchronous inputs that are oversampled in the clk domain. There is no tck clock domain, and all logic is clocked by clk.

---
 rtl/jtag_dtm.sv | 136 +++++++++++++
 tb/tb_jtag_dtm.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/jtag_dtm.sv
// jtag_dtm: JTAG debug transport oversampling TAP pins in clk and issuing DMI requests.
// Optional DTM_TRST_EN adds a synchronized active-low trstn that holds the TAP in reset.
module jtag_dtm #(
  parameter logic [31:0] IDCODE_VALUE = 32'h20000913,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        resetn,
`ifdef DTM_TRST_EN
  input  logic        trstn,
`endif
  input  logic        tck,
  input  logic        tms,
  input  logic        tdi,
  output logic        tdo,
  output logic        dmi_valid,
  output logic        dmi_wr,
  output logic [6:0]  dmi_addr,
  output logic [31:0] dmi_wdata,
  input  logic [31:0] dmi_rdata
);
  localparam logic [3:0] TLR = 4'd0, RTI = 4'd1, SEL_DR = 4'd2, CAP_DR = 4'd3,
                         SH_DR = 4'd4, EX1_DR = 4'd5, PA_DR = 4'd6, EX2_DR = 4'd7,
                         UP_DR = 4'd8, SEL_IR = 4'd9, CAP_IR = 4'd10, SH_IR = 4'd11,
                         EX1_IR = 4'd12, PA_IR = 4'd13, EX2_IR = 4'd14, UP_IR = 4'd15;
  localparam logic [4:0] IR_IDCODE = 5'h01, IR_DTMCS = 5'h10, IR_DMI = 5'h11;
  logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync;
  logic tck_q, tck_s, tms_s, tdi_s, tck_rise, tck_fall, tap_en, upd_dmi, rd_pend;
  logic [3:0] state, state_nxt;
  logic [4:0] ir, ir_sr;
  logic [40:0] dr, dr_cap, dr_sh;
  logic [6:0] last_addr;
  logic [31:0] read_hold;
  assign tck_s = tck_sync[SYNC_STAGES-1];
  assign tms_s = tms_sync[SYNC_STAGES-1];
  assign tdi_s = tdi_sync[SYNC_STAGES-1];
  assign tck_rise = tck_s & ~tck_q;
  assign tck_fall = ~tck_s & tck_q;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tck_sync <= '0;
      tms_sync <= '0;
      tdi_sync <= '0;
      tck_q <= 1'b0;
    end else begin
      tck_sync <= {tck_sync[SYNC_STAGES-2:0], tck};
      tms_sync <= {tms_sync[SYNC_STAGES-2:0], tms};
      tdi_sync <= {tdi_sync[SYNC_STAGES-2:0], tdi};
      tck_q <= tck_s;
    end
  end
`ifdef DTM_TRST_EN
  logic [SYNC_STAGES-1:0] trst_sync;
  always_ff @(posedge clk) begin
    if (!resetn) trst_sync <= '0;
    else trst_sync <= {trst_sync[SYNC_STAGES-2:0], trstn};
  end
  assign tap_en = trst_sync[SYNC_STAGES-1];
`else
  assign tap_en = 1'b1;
`endif
  always_comb begin
    state_nxt = state;
    case (state)
      TLR:     state_nxt = tms_s ? TLR : RTI;
      RTI:     state_nxt = tms_s ? SEL_DR : RTI;
      SEL_DR:  state_nxt = tms_s ? SEL_IR : CAP_DR;
      CAP_DR:  state_nxt = tms_s ? EX1_DR : SH_DR;
      SH_DR:   state_nxt = tms_s ? EX1_DR : SH_DR;
      EX1_DR:  state_nxt = tms_s ? UP_DR : PA_DR;
      PA_DR:   state_nxt = tms_s ? EX2_DR : PA_DR;
      EX2_DR:  state_nxt = tms_s ? UP_DR : SH_DR;
      UP_DR:   state_nxt = tms_s ? SEL_DR : RTI;
      SEL_IR:  state_nxt = tms_s ? TLR : CAP_IR;
      CAP_IR:  state_nxt = tms_s ? EX1_IR : SH_IR;
      SH_IR:   state_nxt = tms_s ? EX1_IR : SH_IR;
      EX1_IR:  state_nxt = tms_s ? UP_IR : PA_IR;
      PA_IR:   state_nxt = tms_s ? EX2_IR : PA_IR;
      EX2_IR:  state_nxt = tms_s ? UP_IR : SH_IR;
      default: state_nxt = tms_s ? SEL_DR : RTI;
    endcase
  end
  always_comb begin
    dr_cap = ir == IR_IDCODE ? {9'd0, IDCODE_VALUE} :
             ir == IR_DTMCS  ? 41'h71 :
             ir == IR_DMI    ? {last_addr, read_hold, 2'b00} : '0;
    dr_sh  = ir == IR_DMI ? {tdi_s, dr[40:1]} :
             (ir == IR_IDCODE || ir == IR_DTMCS) ? {9'd0, tdi_s, dr[31:1]} : {40'd0, tdi_s};
  end
  assign upd_dmi = tck_rise & (state_nxt == UP_DR) & (ir == IR_DMI);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= TLR;
      ir <= IR_IDCODE;
      ir_sr <= '0;
      dr <= '0;
      tdo <= 1'b0;
      dmi_valid <= 1'b0;
      dmi_wr <= 1'b0;
      dmi_addr <= '0;
      dmi_wdata <= '0;
      last_addr <= '0;
    end else if (!tap_en) begin
      state <= TLR;
      ir <= IR_IDCODE;
      tdo <= 1'b0;
      dmi_valid <= 1'b0;
    end else begin
      // op 1 (read) and 2 (write) are exactly the ops whose two bits differ
      dmi_valid <= upd_dmi & (^dr[1:0]);
      if (upd_dmi & (^dr[1:0])) begin
        dmi_wr <= dr[1];
        dmi_addr <= dr[40:34];
        dmi_wdata <= dr[33:2];
      end
      if (upd_dmi) last_addr <= dr[40:34];
      if (tck_fall) tdo <= state == SH_IR ? ir_sr[0] : state == SH_DR ? dr[0] : 1'b0;
      if (tck_rise) begin
        state <= state_nxt;
        ir_sr <= state == CAP_IR ? 5'b00001 : state == SH_IR ? {tdi_s, ir_sr[4:1]} : ir_sr;
        dr <= state == CAP_DR ? dr_cap : state == SH_DR ? dr_sh : dr;
        ir <= state_nxt == TLR ? IR_IDCODE : state_nxt == UP_IR ? ir_sr : ir;
      end
    end
  end
  // downstream registers rdata one clk after the strobe, so sample it one clk later still
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_pend <= 1'b0;
      read_hold <= '0;
    end else begin
      rd_pend <= dmi_valid & ~dmi_wr;
      if (rd_pend) read_hold <= dmi_rdata;
    end
  end
endmodule

// File: tb/tb_jtag_dtm.sv
// tb_jtag_dtm: directed JTAG scans with a DMI strobe scoreboard and a registered-rdata model.
module tb_jtag_dtm;
  typedef struct packed {
    logic        wr;
    logic [6:0]  addr;
    logic [31:0] wdata;
  } txn_t;
  localparam logic [31:0] RD_VAL = 32'h12345678;
  logic clk = 1'b0, resetn = 1'b0, tck = 1'b0, tms = 1'b1, tdi = 1'b0;
  logic tdo, dmi_valid, dmi_wr;
  logic [6:0] dmi_addr;
  logic [31:0] dmi_wdata, dmi_rdata;
  int checks = 0, errors = 0, rd_ptr = 0;
  txn_t exp_q[$], obs_q[$];
  always #5 clk = ~clk;
  jtag_dtm dut (
    .clk(clk), .resetn(resetn),
`ifdef DTM_TRST_EN
    .trstn(1'b1),
`endif
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo),
    .dmi_valid(dmi_valid), .dmi_wr(dmi_wr), .dmi_addr(dmi_addr),
    .dmi_wdata(dmi_wdata), .dmi_rdata(dmi_rdata)
  );
  always @(posedge clk) dmi_rdata <= (dmi_valid && !dmi_wr) ? RD_VAL : 32'hBAD0BAD0;
  always @(negedge clk) if (dmi_valid === 1'b1) obs_q.push_back({dmi_wr, dmi_addr, dmi_wdata});
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic jclk(input logic t, input logic d, output logic o);
    @(negedge clk);
    tck = 1'b0;
    tms = t;
    tdi = d;
    repeat (6) @(negedge clk);
    o = tdo;
    tck = 1'b1;
    repeat (6) @(negedge clk);
  endtask
  task automatic ir_scan(input logic [4:0] v, output logic [4:0] o);
    logic b;
    jclk(1, 0, b); jclk(1, 0, b); jclk(0, 0, b); jclk(0, 0, b);
    for (int i = 0; i < 5; i++) begin
      jclk(i == 4, v[i], b);
      o[i] = b;
    end
    jclk(1, 0, b); jclk(0, 0, b);
  endtask
  task automatic dr_scan(input logic [40:0] v, input int n, output logic [40:0] o);
    logic b;
    o = '0;
    jclk(1, 0, b); jclk(0, 0, b); jclk(0, 0, b);
    for (int i = 0; i < n; i++) begin
      jclk(i == n - 1, v[i], b);
      o[i] = b;
    end
    jclk(1, 0, b); jclk(0, 0, b);
  endtask
  task automatic check_strobes(input string tag);
    txn_t e, o;
    chk({tag, "_count"}, 64'(obs_q.size() - rd_ptr), 64'(exp_q.size()));
    while (exp_q.size() > 0 && rd_ptr < obs_q.size()) begin
      e = exp_q.pop_front();
      o = obs_q[rd_ptr];
      rd_ptr++;
      chk({tag, "_wr"}, 64'(o.wr), 64'(e.wr));
      chk({tag, "_addr"}, 64'(o.addr), 64'(e.addr));
      if (e.wr) chk({tag, "_wdata"}, 64'(o.wdata), 64'(e.wdata));
    end
    exp_q.delete();
    rd_ptr = obs_q.size();
  endtask
  initial begin
    logic b;
    logic [4:0] ir_o;
    logic [40:0] dr_o;
    repeat (4) @(negedge clk);
    chk("rst_tdo", 64'(tdo), 64'(0));
    chk("rst_valid", 64'(dmi_valid), 64'(0));
    chk("rst_wr", 64'(dmi_wr), 64'(0));
    chk("rst_addr", 64'(dmi_addr), 64'(0));
    chk("rst_wdata", 64'(dmi_wdata), 64'(0));
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) jclk(1, 0, b);
    jclk(0, 0, b);
    dr_scan('0, 32, dr_o);
    chk("idcode", 64'(dr_o[31:0]), 64'(32'h20000913));
    ir_scan(5'h10, ir_o);
    chk("ir_cap_dtmcs", 64'(ir_o), 64'(5'b00001));
    dr_scan({9'd0, 32'hFFFFFFFF}, 32, dr_o);
    chk("dtmcs_1", 64'(dr_o[31:0]), 64'(32'h71));
    dr_scan('0, 32, dr_o);
    chk("dtmcs_2", 64'(dr_o[31:0]), 64'(32'h71));
    check_strobes("dtmcs");
    ir_scan(5'h11, ir_o);
    chk("ir_cap_dmi", 64'(ir_o), 64'(5'b00001));
    exp_q.push_back({1'b1, 7'h04, 32'hDEADBEEF});
    dr_scan({7'h04, 32'hDEADBEEF, 2'd2}, 41, dr_o);
    chk("wr_capture", 64'(dr_o), 64'(0));
    check_strobes("dmi_write");
    chk("wr_addr_hold", 64'(dmi_addr), 64'(7'h04));
    chk("wr_wdata_hold", 64'(dmi_wdata), 64'(32'hDEADBEEF));
    exp_q.push_back({1'b0, 7'h04, 32'h0});
    dr_scan({7'h04, 32'h0, 2'd1}, 41, dr_o);
    chk("rd_capture_1", 64'(dr_o), 64'({7'h04, 32'h0, 2'b00}));
    check_strobes("dmi_read");
    dr_scan({7'h09, 32'h0, 2'd0}, 41, dr_o);
    chk("rd_capture_2", 64'(dr_o), 64'({7'h04, RD_VAL, 2'b00}));
    dr_scan({7'h0A, 32'h55, 2'd3}, 41, dr_o);
    chk("nop_capture", 64'(dr_o), 64'({7'h09, RD_VAL, 2'b00}));
    check_strobes("dmi_nop");
    ir_scan(5'h1F, ir_o);
    chk("ir_cap_byp", 64'(ir_o), 64'(5'b00001));
    dr_scan({33'd0, 8'hA5}, 8, dr_o);
    chk("bypass", 64'(dr_o[7:0]), 64'(8'h4A));
    ir_scan(5'h11, ir_o);
    jclk(1, 0, b); jclk(0, 0, b); jclk(0, 0, b);
    for (int i = 0; i < 20; i++) begin
      dr_o = {7'h05, 32'hCAFEF00D, 2'd2};
      jclk(0, dr_o[i], b);
    end
    @(negedge clk);
    tck = 1'b0;
    repeat (6) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("mid_tdo", 64'(tdo), 64'(0));
    chk("mid_valid", 64'(dmi_valid), 64'(0));
    chk("mid_wr", 64'(dmi_wr), 64'(0));
    chk("mid_addr", 64'(dmi_addr), 64'(0));
    chk("mid_wdata", 64'(dmi_wdata), 64'(0));
    jclk(0, 0, b);
    dr_scan('0, 32, dr_o);
    chk("mid_idcode", 64'(dr_o[31:0]), 64'(32'h20000913));
    check_strobes("mid_reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
